mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles spent in RD or WR waiting for MEM_R before the access aborts (legal range 1..15).
REQ-002 SHALL have port CLK, input, 1, the single system clock; all state updates on rising edge.
REQ-003 SHALL have port RESET_N, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port Start, input, 1, request strobe; sampled only in IDLE.
REQ-005 SHALL have port Op, input, 3, access type: 000 LD, 001 ST, 010 LDI, 011 STI, 100 TRAP; others illegal.
REQ-006 SHALL have port MEM_R, input, 1, memory ready; completes the current read or write cycle.
REQ-007 SHALL have port MARMUX_Control, output, 1, MARMUX select: 1 = zero-extended IR[7:0], 0 = adder.
REQ-008 SHALL have ports GateMARMUX, GateMDR, LD_MAR, LD_MDR, MIO_EN and R_W, outputs, 1 each: bus gates, register loads, memory enable, and write (1) / read (0).
REQ-009 SHALL have ports Busy, Done and Err, outputs, 1 each: controller not in IDLE, access complete (1-cycle pulse), and illegal op or timeout (1-cycle pulse).

Function
REQ-010 SHALL be a Moore FSM: IDLE, MAR, RD, IND, SMDR, WR, DONE; all outputs decode from registered state, registered Op, and a 1-bit Ind flag.
REQ-011 SHALL, in IDLE with Start=1 and legal Op, latch Op, clear Ind, and enter MAR next cycle.
REQ-012 SHALL, in IDLE with Start=1 and illegal Op, pulse Err for exactly one cycle and remain in IDLE.
REQ-013 SHALL ignore Start outside IDLE; no queuing.
REQ-014 SHALL, in MAR, assert GateMARMUX and LD_MAR, with MARMUX_Control=1 only when Op=TRAP; next state SMDR for ST, otherwise RD.
REQ-015 SHALL, in RD, assert MIO_EN with R_W=0, and assert LD_MDR only in the cycle MEM_R=1.
REQ-016 SHALL leave RD when MEM_R=1, going to IND for LDI/STI with Ind=0 and to DONE otherwise.
REQ-017 SHALL, in IND, assert GateMDR and LD_MAR and set Ind=1; next state RD for LDI, SMDR for STI.
REQ-018 SHALL, in SMDR, assert LD_MDR with MIO_EN=0, loading the source value from the bus; next state WR.
REQ-019 SHALL, in WR, assert MIO_EN and R_W=1 until MEM_R=1, then go to DONE.
REQ-020 SHALL, in DONE, pulse Done for one cycle, assert GateMDR for LD/LDI/TRAP only, and return to IDLE.
REQ-021 SHALL hold Busy=1 in every state except IDLE.
REQ-022 SHALL use a 4-bit wait counter that clears on every entry to RD or WR and increments each cycle MEM_R=0; when it reaches TIMEOUT with MEM_R=0, the controller pulses Err, drops MIO_EN, and goes to IDLE without Done.
REQ-023 SHALL give MEM_R=1 priority over timeout in the same cycle, so the access completes normally.
REQ-024 SHALL keep MARMUX_Control=0 in every state other than MAR with Op=TRAP.
REQ-025 SHALL never assert Done and Err in the same cycle.

Reset
REQ-026 SHALL, on RESET_N=0 and regardless of CLK, force IDLE, Ind=0, counter=0, latched Op=000, and every output to 0.
REQ-027 SHALL, if reset occurs mid-access (any state), abandon the access without a Done or Err pulse; the first legal Start after release is accepted normally.

Verification
REQ-028 SHALL cover LD with MEM_R high on the first RD cycle: states MAR, RD, DONE; Done on the 3rd cycle after Start; LD_MDR high for 1 cycle.
REQ-029 SHALL cover TRAP: MARMUX_Control=1 and GateMARMUX=1 only in MAR; GateMDR=1 in DONE.
REQ-030 SHALL cover STI with MEM_R delayed 2 cycles per access: sequence MAR, RD×3, IND, SMDR, WR×3, DONE; R_W=1 only in WR; Done 10 cycles after Start.
REQ-031 SHALL cover Op=101 with Start: Err pulses 1 cycle, Busy stays 0.
REQ-032 SHALL cover TIMEOUT=15 with MEM_R held low in RD: Err after 15 RD cycles, then IDLE with no Done.
REQ-033 SHALL cover RESET_N dropped during WR: all outputs 0 immediately; a following LD completes in 3 cycles.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Request/handshake and datapath-control bundle between the requester/memory side
// and the memory access controller.
interface mem_access_ctrl_if;
  logic       Start;
  logic [2:0] Op;
  logic       MEM_R;
  logic       MARMUX_Control;
  logic       GateMARMUX;
  logic       GateMDR;
  logic       LD_MAR;
  logic       LD_MDR;
  logic       MIO_EN;
  logic       R_W;
  logic       Busy;
  logic       Done;
  logic       Err;

  modport master (
    output Start, Op, MEM_R,
    input  MARMUX_Control, GateMARMUX, GateMDR, LD_MAR, LD_MDR,
           MIO_EN, R_W, Busy, Done, Err
  );

  modport slave (
    input  Start, Op, MEM_R,
    output MARMUX_Control, GateMARMUX, GateMDR, LD_MAR, LD_MDR,
           MIO_EN, R_W, Busy, Done, Err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller: sequences MAR/MDR loads and memory read/write cycles
// for LD/ST/LDI/STI/TRAP, with a wait-cycle timeout on the memory ready handshake.
module mem_access_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RESET_N,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAR  = 3'd1,
    ST_RD   = 3'd2,
    ST_IND  = 3'd3,
    ST_SMDR = 3'd4,
    ST_WR   = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam logic [2:0] OP_LD   = 3'd0;
  localparam logic [2:0] OP_ST   = 3'd1;
  localparam logic [2:0] OP_LDI  = 3'd2;
  localparam logic [2:0] OP_STI  = 3'd3;
  localparam logic [2:0] OP_TRAP = 3'd4;

  // Last count value before the wait limit; one more idle MEM_R cycle aborts.
  localparam logic [3:0] WAIT_LAST_C = 4'(TIMEOUT - 1);

  state_t     state_r;
  state_t     state_s;
  logic [2:0] op_r;
  logic       ind_r;
  logic [3:0] cnt_r;
  logic       err_r;
  logic       accept_s;
  logic       illegal_s;
  logic       timeout_s;
  logic       waiting_s;

  // Next-state selection plus the accept/illegal/timeout events that feed the registers.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    illegal_s = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.Start) begin
          if (bus.Op <= OP_TRAP) begin
            accept_s = 1'b1;
            state_s  = ST_MAR;
          end else begin
            illegal_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MAR: begin
        if (op_r == OP_ST) begin
          state_s = ST_SMDR;
        end else begin
          state_s = ST_RD;
        end
      end
      ST_RD: begin
        if (bus.MEM_R) begin
          if (((op_r == OP_LDI) || (op_r == OP_STI)) && !ind_r) begin
            state_s = ST_IND;
          end else begin
            state_s = ST_DONE;
          end
        end else if (cnt_r == WAIT_LAST_C) begin
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_RD;
        end
      end
      ST_IND: begin
        if (op_r == OP_LDI) begin
          state_s = ST_RD;
        end else begin
          state_s = ST_SMDR;
        end
      end
      ST_SMDR: state_s = ST_WR;
      ST_WR: begin
        if (bus.MEM_R) begin
          state_s = ST_DONE;
        end else if (cnt_r == WAIT_LAST_C) begin
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_WR;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Counter runs only while a read/write keeps waiting; any exit or re-entry restarts it at zero.
  assign waiting_s = ((state_r == ST_RD) || (state_r == ST_WR)) && !bus.MEM_R && !timeout_s;

  // State, latched op, indirection flag, wait counter and the registered error pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
      op_r    <= 3'd0;
      ind_r   <= 1'b0;
      cnt_r   <= 4'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      err_r   <= illegal_s | timeout_s;
      cnt_r   <= waiting_s ? (cnt_r + 4'd1) : 4'd0;
      if (accept_s) begin
        op_r  <= bus.Op;
        ind_r <= 1'b0;
      end else if (state_r == ST_IND) begin
        op_r  <= op_r;
        ind_r <= 1'b1;
      end else begin
        op_r  <= op_r;
        ind_r <= ind_r;
      end
    end
  end

  // Output decode from registered state/op; LD_MDR in RD follows MEM_R to capture the read data.
  always_comb begin
    bus.MARMUX_Control = 1'b0;
    bus.GateMARMUX     = 1'b0;
    bus.GateMDR        = 1'b0;
    bus.LD_MAR         = 1'b0;
    bus.LD_MDR         = 1'b0;
    bus.MIO_EN         = 1'b0;
    bus.R_W            = 1'b0;
    bus.Done           = 1'b0;
    bus.Busy           = (state_r != ST_IDLE);
    bus.Err            = err_r;
    case (state_r)
      ST_IDLE: bus.Busy = 1'b0;
      ST_MAR: begin
        bus.GateMARMUX     = 1'b1;
        bus.LD_MAR         = 1'b1;
        bus.MARMUX_Control = (op_r == OP_TRAP);
      end
      ST_RD: begin
        bus.MIO_EN = 1'b1;
        bus.LD_MDR = bus.MEM_R;
      end
      ST_IND: begin
        bus.GateMDR = 1'b1;
        bus.LD_MAR  = 1'b1;
      end
      ST_SMDR: bus.LD_MDR = 1'b1;
      ST_WR: begin
        bus.MIO_EN = 1'b1;
        bus.R_W    = 1'b1;
      end
      ST_DONE: begin
        bus.Done    = 1'b1;
        bus.GateMDR = (op_r == OP_LD) || (op_r == OP_LDI) || (op_r == OP_TRAP);
      end
      default: bus.Busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: per-cycle output vectors compared against
// hand-written expected sequences for each access type, timeout and reset cases.
module tb_mem_access_ctrl;

  logic CLK = 1'b0;
  logic RESET_N;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(15)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  // {MARMUX_Control, GateMARMUX, GateMDR, LD_MAR, LD_MDR, MIO_EN, R_W, Busy, Done, Err}
  logic [9:0] obs_s;
  assign obs_s = {bus.MARMUX_Control, bus.GateMARMUX, bus.GateMDR, bus.LD_MAR, bus.LD_MDR,
                  bus.MIO_EN, bus.R_W, bus.Busy, bus.Done, bus.Err};

  localparam logic [9:0] O_IDLE     = 10'b0000000000;
  localparam logic [9:0] O_MAR      = 10'b0101000100;
  localparam logic [9:0] O_MAR_TRAP = 10'b1101000100;
  localparam logic [9:0] O_RD_WAIT  = 10'b0000010100;
  localparam logic [9:0] O_RD_RDY   = 10'b0000110100;
  localparam logic [9:0] O_IND      = 10'b0011000100;
  localparam logic [9:0] O_SMDR     = 10'b0000100100;
  localparam logic [9:0] O_WR       = 10'b0000011100;
  localparam logic [9:0] O_DONE     = 10'b0000000110;
  localparam logic [9:0] O_DONE_G   = 10'b0010000110;
  localparam logic [9:0] O_ERR      = 10'b0000000001;

  logic [9:0] exp_q[$];
  logic       mr_q[$];

  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Start one request, then walk exp_q/mr_q one cycle per entry, checking at the falling edge.
  task automatic run_seq(input string tag, input logic [2:0] op, input logic hold_start);
    @(posedge CLK); #1;
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.MEM_R = 1'b0;
    @(negedge CLK);
    check_eq($sformatf("%s[start]", tag), obs_s, O_IDLE);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge CLK); #1;
      bus.Start = (hold_start && (i < exp_q.size() - 1)) ? 1'b1 : 1'b0;
      bus.Op    = 3'd1;
      bus.MEM_R = mr_q[i];
      @(negedge CLK);
      check_eq($sformatf("%s[%0d]", tag, i), obs_s, exp_q[i]);
    end
    bus.Start = 1'b0;
    bus.MEM_R = 1'b0;
  endtask

  initial begin
    RESET_N   = 1'b0;
    bus.Start = 1'b0;
    bus.Op    = 3'd0;
    bus.MEM_R = 1'b0;
    #1;
    check_eq("reset_outputs", obs_s, O_IDLE);
    repeat (2) @(posedge CLK);
    #2 RESET_N = 1'b1;
    @(negedge CLK);
    check_eq("post_reset_idle", obs_s, O_IDLE);

    // LD, memory ready on the first read cycle: Done lands on the third cycle.
    exp_q = '{O_MAR, O_RD_RDY, O_DONE_G, O_IDLE};
    mr_q  = '{1'b0, 1'b1, 1'b0, 1'b0};
    run_seq("ld_fast", 3'd0, 1'b0);

    // TRAP: MARMUX select only in MAR, GateMDR in DONE.
    exp_q = '{O_MAR_TRAP, O_RD_RDY, O_DONE_G, O_IDLE};
    mr_q  = '{1'b0, 1'b1, 1'b0, 1'b0};
    run_seq("trap", 3'd4, 1'b0);

    // STI with two wait cycles per access; Start held high meanwhile must not queue.
    exp_q = '{O_MAR, O_RD_WAIT, O_RD_WAIT, O_RD_RDY, O_IND, O_SMDR,
              O_WR, O_WR, O_WR, O_DONE, O_IDLE};
    mr_q  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    run_seq("sti_slow", 3'd3, 1'b1);

    // LDI: two reads, second one after the indirection step, no further IND.
    exp_q = '{O_MAR, O_RD_RDY, O_IND, O_RD_RDY, O_DONE_G, O_IDLE};
    mr_q  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    run_seq("ldi", 3'd2, 1'b0);

    // ST goes straight from MAR to SMDR; no GateMDR in DONE.
    exp_q = '{O_MAR, O_SMDR, O_WR, O_DONE, O_IDLE};
    mr_q  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    run_seq("st", 3'd1, 1'b0);

    // Illegal ops: one-cycle Err, never busy.
    exp_q = '{O_ERR, O_IDLE};
    mr_q  = '{1'b0, 1'b0};
    run_seq("op101", 3'd5, 1'b0);
    run_seq("op111", 3'd7, 1'b0);

    // LD with memory never ready: 15 read cycles then Err in IDLE, no Done.
    exp_q = '{O_MAR};
    mr_q  = '{1'b0};
    for (int k = 0; k < 15; k++) begin
      exp_q.push_back(O_RD_WAIT);
      mr_q.push_back(1'b0);
    end
    exp_q.push_back(O_ERR);
    mr_q.push_back(1'b0);
    exp_q.push_back(O_IDLE);
    mr_q.push_back(1'b0);
    run_seq("rd_timeout", 3'd0, 1'b0);

    // Ready arriving on the last allowed read cycle wins over the timeout.
    exp_q = '{O_MAR};
    mr_q  = '{1'b0};
    for (int k = 0; k < 14; k++) begin
      exp_q.push_back(O_RD_WAIT);
      mr_q.push_back(1'b0);
    end
    exp_q.push_back(O_RD_RDY);
    mr_q.push_back(1'b1);
    exp_q.push_back(O_DONE_G);
    mr_q.push_back(1'b0);
    exp_q.push_back(O_IDLE);
    mr_q.push_back(1'b0);
    run_seq("rd_edge_ready", 3'd0, 1'b0);

    // ST with memory never ready in WR: timeout also applies to writes.
    exp_q = '{O_MAR, O_SMDR};
    mr_q  = '{1'b0, 1'b0};
    for (int k = 0; k < 15; k++) begin
      exp_q.push_back(O_WR);
      mr_q.push_back(1'b0);
    end
    exp_q.push_back(O_ERR);
    mr_q.push_back(1'b0);
    exp_q.push_back(O_IDLE);
    mr_q.push_back(1'b0);
    run_seq("wr_timeout", 3'd1, 1'b0);

    // Reset dropped mid-write: outputs clear without waiting for a clock edge.
    @(posedge CLK); #1;
    bus.Start = 1'b1;
    bus.Op    = 3'd1;
    bus.MEM_R = 1'b0;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check_eq("rst_in_wr", obs_s, O_WR);
    #2 RESET_N = 1'b0;
    #1;
    check_eq("rst_async", obs_s, O_IDLE);
    @(posedge CLK); #1;
    check_eq("rst_held", obs_s, O_IDLE);
    RESET_N = 1'b1;
    @(negedge CLK);
    check_eq("rst_release", obs_s, O_IDLE);

    exp_q = '{O_MAR, O_RD_RDY, O_DONE_G, O_IDLE};
    mr_q  = '{1'b0, 1'b1, 1'b0, 1'b0};
    run_seq("ld_after_rst", 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
